// File: rtl/mem_link_master_pkg.sv
// Shared definitions for the memory-link initiator: message lengths,
// payload field offsets and FSM state encoding.
package mem_link_defs;

  localparam logic [4:0]  MSG_LEN_READ  = 5'd5;
  localparam logic [4:0]  MSG_LEN_WRITE = 5'd9;
  localparam logic [4:0]  MSG_LEN_REPLY = 5'd4;
  localparam int unsigned MSG_BITS      = 72;

  localparam int unsigned DATA_LO = 0;
  localparam int unsigned ADDR_LO = 32;
  localparam int unsigned MASK_LO = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_RESP,
    ST_RESP
  } state_e;

endpackage

// File: rtl/mem_link_master_pack.sv
// Combinational packer turning a single-word load/store request into a
// framed message (length + payload) for the transceiver.
module mem_link_pack
  import mem_link_defs::*;
(
  input  logic                we_i,
  input  logic [31:0]         addr_i,
  input  logic [31:0]         wdata_i,
  input  logic [3:0]          mask_i,
  output logic [4:0]          length_o,
  output logic [MSG_BITS-1:0] data_o
);

  always_comb begin
    data_o = '0;
    if (we_i) begin
      length_o                = MSG_LEN_WRITE;
      data_o[DATA_LO +: 32]   = wdata_i;
      data_o[ADDR_LO +: 32]   = addr_i;
      data_o[MASK_LO +: 4]    = mask_i;
    end else begin
      // Bit 32 stays 0: the responder's read discriminator.
      length_o                = MSG_LEN_READ;
      data_o[DATA_LO +: 32]   = addr_i;
    end
  end

endmodule

// File: rtl/mem_link_master.sv
// Initiator side of the simulation memory link: sends one load/store message
// at a time over transceiver channel 0 and returns load data or a timeout.
module mem_link_master
  import mem_link_defs::*;
#(
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic                clk,
  input  logic                RST_N,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_wdata,
  input  logic [3:0]          req_mask,
  output logic                resp_valid,
  output logic [31:0]         resp_rdata,
  output logic                resp_err,
  output logic                send_flag,
  output logic [4:0]          send_length,
  output logic [MSG_BITS-1:0] send_data,
  input  logic                sendable,
  output logic                recv_flag,
  input  logic [4:0]          recv_length,
  input  logic [MSG_BITS-1:0] recv_data,
  input  logic                recvable
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit          TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [4:0]            len_q, len_d;
  logic [MSG_BITS-1:0]   msg_q, msg_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [4:0]            pack_len;
  logic [MSG_BITS-1:0]   pack_data;
  logic                  unused_recv;

  assign unused_recv = ^recv_data[MSG_BITS-1:32];

  // Packing from the live request lets the message register itself act as
  // the latched request, so send_* are driven straight from flops.
  mem_link_pack u_pack (
    .we_i     (req_we),
    .addr_i   (req_addr),
    .wdata_i  (req_wdata),
    .mask_i   (req_mask),
    .length_o (pack_len),
    .data_o   (pack_data)
  );

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      len_q   <= '0;
      msg_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      len_q   <= len_d;
      msg_q   <= msg_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    len_d     = len_q;
    msg_d     = msg_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    send_flag = 1'b0;
    recv_flag = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          we_d    = req_we;
          len_d   = pack_len;
          msg_d   = pack_data;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (sendable) begin
          send_flag = 1'b1;
          cnt_d     = '0;
          rdata_d   = '0;
          err_d     = 1'b0;
          state_d   = we_q ? ST_RESP : ST_WAIT_RESP;
        end
      end
      ST_WAIT_RESP: begin
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        if (recvable) begin
          recv_flag = 1'b1;
          if (recv_length == MSG_LEN_REPLY) begin
            rdata_d = recv_data[31:0];
            err_d   = 1'b0;
            state_d = ST_RESP;
          end
        end
        // A valid reply in the timeout cycle has already moved us to RESP.
        if (TO_EN && state_d == ST_WAIT_RESP && cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready   = RST_N && (state_q == ST_IDLE);
  assign resp_valid  = (state_q == ST_RESP);
  assign resp_rdata  = rdata_q;
  assign resp_err    = err_q;
  assign send_length = len_q;
  assign send_data   = msg_q;

endmodule
